// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone-classic arbiter: round-robin grant held for the whole cyc tenure,
// owner-only ack/err routing, and a per-transfer watchdog that frees a hung bus.
module wb_arbiter_2m #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_cyc,
    input  logic                  m0_stb,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_data_out,
    output logic [DATA_WIDTH-1:0] m0_data_in,
    output logic                  m0_ack,
    output logic                  m0_err,
    input  logic                  m1_cyc,
    input  logic                  m1_stb,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_data_out,
    output logic [DATA_WIDTH-1:0] m1_data_in,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic                  s_cyc,
    output logic                  s_stb,
    output logic                  s_we,
    output logic [ADDR_WIDTH-1:0] s_addr,
    output logic [DATA_WIDTH-1:0] s_data_out,
    input  logic [DATA_WIDTH-1:0] s_data_in,
    input  logic                  s_ack,
    output logic [1:0]            grant
);

    // A zero timeout would give a zero-width counter, so keep one dummy bit held at 0.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        GNT0 = 2'b01,
        GNT1 = 2'b10
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             last;
    logic [CNT_W-1:0] wd_count;
    logic [1:0]       err_lock;
    logic             req0;
    logic             req1;
    logic             timeout;

    // A master that just timed out may not compete again until it has dropped cyc.
    assign req0 = m0_cyc & ~err_lock[0];
    assign req1 = m1_cyc & ~err_lock[1];

    assign timeout = (TIMEOUT_CYCLES != 0) && (state != IDLE)
                     && (wd_count == CNT_W'(TIMEOUT_CYCLES)) && !s_ack;

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req0 && req1)
                    next_state = last ? GNT0 : GNT1;
                else if (req0)
                    next_state = GNT0;
                else if (req1)
                    next_state = GNT1;
            end
            GNT0: if (!m0_cyc) next_state = req1 ? GNT1 : IDLE;
            GNT1: if (!m1_cyc) next_state = req0 ? GNT0 : IDLE;
            default: next_state = IDLE;
        endcase
        if (timeout)
            next_state = IDLE;
    end

    always_comb begin
        s_cyc      = 1'b0;
        s_stb      = 1'b0;
        s_we       = 1'b0;
        s_addr     = '0;
        s_data_out = '0;
        case (state)
            GNT0: begin
                s_cyc      = m0_cyc;
                s_stb      = m0_stb;
                s_we       = m0_we;
                s_addr     = m0_addr;
                s_data_out = m0_data_out;
            end
            GNT1: begin
                s_cyc      = m1_cyc;
                s_stb      = m1_stb;
                s_we       = m1_we;
                s_addr     = m1_addr;
                s_data_out = m1_data_out;
            end
            default: ;
        endcase
    end

    assign grant      = {state == GNT1, state == GNT0};
    assign m0_ack     = s_ack & grant[0] & m0_stb;
    assign m1_ack     = s_ack & grant[1] & m1_stb;
    assign m0_err     = timeout & grant[0];
    assign m1_err     = timeout & grant[1];
    assign m0_data_in = s_data_in;
    assign m1_data_in = s_data_in;

    // The watchdog measures one stalled transfer of one owner, so any ack or owner change restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            last     <= 1'b1;
            wd_count <= '0;
            err_lock <= 2'b00;
        end else begin
            state <= next_state;
            if (next_state == GNT0)
                last <= 1'b0;
            else if (next_state == GNT1)
                last <= 1'b1;

            if ((TIMEOUT_CYCLES == 0) || (state == IDLE) || (next_state != state) || s_ack)
                wd_count <= '0;
            else if (s_stb)
                wd_count <= wd_count + CNT_W'(1);

            if (m0_err)
                err_lock[0] <= 1'b1;
            else if (!m0_cyc)
                err_lock[0] <= 1'b0;

            if (m1_err)
                err_lock[1] <= 1'b1;
            else if (!m1_cyc)
                err_lock[1] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: an owner-level arbitration model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_wb_arbiter_2m;

    localparam int TO = 8;

    logic        clk;
    logic        rst;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_addr, m0_data_out, m0_data_in;
    logic        m0_ack, m0_err;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_addr, m1_data_out, m1_data_in;
    logic        m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_addr, s_data_out, s_data_in;
    logic        s_ack;
    logic [1:0]  grant;
    logic        ack_en;

    int compared   = 0;
    int mismatched = 0;

    wb_arbiter_2m #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_data_out(m0_data_out), .m0_data_in(m0_data_in), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_data_out(m1_data_out), .m1_data_in(m1_data_in), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_addr(s_addr),
        .s_data_out(s_data_out), .s_data_in(s_data_in), .s_ack(s_ack), .grant(grant)
    );

    // Zero-wait slave: acks any strobe it sees while enabled.
    assign s_ack = ack_en & s_stb;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: owner (-1 none), last owner, stalled-wait count, post-error locks.
    int own      = -1;
    int mlast    = 1;
    int wait_cnt = 0;
    bit lock0    = 0;
    bit lock1    = 0;

    logic [1:0]  exp_grant;
    logic        exp_s_cyc, exp_s_stb, exp_s_we, exp_sack, exp_to;
    logic [31:0] exp_s_addr, exp_s_data_out;
    logic        exp_m0_ack, exp_m1_ack, exp_m0_err, exp_m1_err;

    always_comb begin
        exp_grant      = 2'b00;
        exp_s_cyc      = 1'b0;
        exp_s_stb      = 1'b0;
        exp_s_we       = 1'b0;
        exp_s_addr     = '0;
        exp_s_data_out = '0;
        if (!rst && own == 0) begin
            exp_grant = 2'b01; exp_s_cyc = m0_cyc; exp_s_stb = m0_stb;
            exp_s_we = m0_we; exp_s_addr = m0_addr; exp_s_data_out = m0_data_out;
        end else if (!rst && own == 1) begin
            exp_grant = 2'b10; exp_s_cyc = m1_cyc; exp_s_stb = m1_stb;
            exp_s_we = m1_we; exp_s_addr = m1_addr; exp_s_data_out = m1_data_out;
        end
        exp_sack   = ack_en & exp_s_stb;
        exp_to     = !rst && (own >= 0) && (wait_cnt == TO) && !exp_sack;
        exp_m0_ack = exp_sack && (own == 0) && m0_stb;
        exp_m1_ack = exp_sack && (own == 1) && m1_stb;
        exp_m0_err = exp_to && (own == 0);
        exp_m1_err = exp_to && (own == 1);
    end

    always @(posedge clk or posedge rst) begin : model_update
        int nown;
        bit e0, e1;
        if (rst) begin
            own <= -1; mlast <= 1; wait_cnt <= 0; lock0 <= 0; lock1 <= 0;
        end else begin
            e0 = m0_cyc && !lock0;
            e1 = m1_cyc && !lock1;
            if (exp_to)                   nown = -1;
            else if (own == 0 && m0_cyc)  nown = 0;
            else if (own == 1 && m1_cyc)  nown = 1;
            else if (e0 && e1)            nown = 1 - mlast;
            else if (e0)                  nown = 0;
            else if (e1)                  nown = 1;
            else                          nown = -1;
            if (nown != own || nown < 0 || exp_sack) wait_cnt <= 0;
            else if (exp_s_stb)                      wait_cnt <= wait_cnt + 1;
            if (nown >= 0) mlast <= nown;
            lock0 <= (exp_to && own == 0) ? 1'b1 : (!m0_cyc ? 1'b0 : lock0);
            lock1 <= (exp_to && own == 1) ? 1'b1 : (!m1_cyc ? 1'b0 : lock1);
            own <= nown;
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        check_output("cmp grant", 64'(grant), 64'(exp_grant));
        check_output("cmp s_cyc", 64'(s_cyc), 64'(exp_s_cyc));
        check_output("cmp s_stb", 64'(s_stb), 64'(exp_s_stb));
        check_output("cmp s_we", 64'(s_we), 64'(exp_s_we));
        check_output("cmp s_addr", 64'(s_addr), 64'(exp_s_addr));
        check_output("cmp s_data_out", 64'(s_data_out), 64'(exp_s_data_out));
        check_output("cmp m0_ack", 64'(m0_ack), 64'(exp_m0_ack));
        check_output("cmp m1_ack", 64'(m1_ack), 64'(exp_m1_ack));
        check_output("cmp m0_err", 64'(m0_err), 64'(exp_m0_err));
        check_output("cmp m1_err", 64'(m1_err), 64'(exp_m1_err));
        check_output("cmp m0_data_in", 64'(m0_data_in), 64'(s_data_in));
        check_output("cmp m1_data_in", 64'(m1_data_in), 64'(s_data_in));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int m, input logic cyc, input logic stb, input logic we,
                                  input logic [31:0] addr, input logic [31:0] data);
        if (m == 0) begin
            m0_cyc = cyc; m0_stb = stb; m0_we = we; m0_addr = addr; m0_data_out = data;
        end else begin
            m1_cyc = cyc; m1_stb = stb; m1_we = we; m1_addr = addr; m1_data_out = data;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int stb_at, err_at, err_cnt;
        rst = 1'b0;
        ack_en = 1'b0;
        s_data_in = 32'h0;
        apply_stimulus(0, 0, 0, 0, 32'h0, 32'h0);
        apply_stimulus(1, 0, 0, 0, 32'h0, 32'h0);
        #1 rst = 1'b1;
        @(negedge clk);
        check_output("reset grant", 64'(grant), 64'h0);
        check_output("reset s_cyc", 64'(s_cyc), 64'h0);
        step();
        rst = 1'b0;

        // Single master read from 0x100
        step();
        apply_stimulus(0, 1, 1, 0, 32'h100, 32'h0);
        ack_en = 1'b1;
        s_data_in = 32'hDEADBEEF;
        @(negedge clk);
        check_output("single idle grant", 64'(grant), 64'h0);
        step();
        @(negedge clk);
        check_output("single grant", 64'(grant), 64'h1);
        check_output("single m0_ack", 64'(m0_ack), 64'h1);
        check_output("single m0_data_in", 64'(m0_data_in), 64'hDEADBEEF);
        check_output("single m1_ack", 64'(m1_ack), 64'h0);
        step();
        apply_stimulus(0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        check_output("single release s_cyc", 64'(s_cyc), 64'h0);
        step();

        // Tie from reset: m0 first, m1 handed over with no idle cycle, then m0 first again
        pulse_reset();
        step();
        apply_stimulus(0, 1, 1, 0, 32'h180, 32'h0);
        apply_stimulus(1, 1, 1, 0, 32'h300, 32'h0);
        step();
        @(negedge clk);
        check_output("tie first grant", 64'(grant), 64'h1);
        step();
        apply_stimulus(0, 0, 0, 0, 32'h0, 32'h0);
        step();
        @(negedge clk);
        check_output("tie handoff grant", 64'(grant), 64'h2);
        check_output("tie m1_ack", 64'(m1_ack), 64'h1);
        step();
        apply_stimulus(1, 0, 0, 0, 32'h0, 32'h0);
        step();
        @(negedge clk);
        check_output("tie idle grant", 64'(grant), 64'h0);
        apply_stimulus(0, 1, 1, 0, 32'h184, 32'h0);
        apply_stimulus(1, 1, 1, 0, 32'h304, 32'h0);
        step();
        @(negedge clk);
        check_output("tie repeat grant", 64'(grant), 64'h1);
        step();
        apply_stimulus(0, 0, 0, 0, 32'h0, 32'h0);
        apply_stimulus(1, 0, 0, 0, 32'h0, 32'h0);
        step();

        // Hold under contention: m1 does four writes while m0 waits
        apply_stimulus(1, 1, 1, 1, 32'h200, 32'hA0);
        step();
        apply_stimulus(0, 1, 1, 0, 32'h400, 32'h0);
        @(negedge clk);
        check_output("hold m1 grant", 64'(grant), 64'h2);
        for (int i = 1; i < 4; i++) begin
            step();
            apply_stimulus(1, 1, 1, 1, 32'h200 + 32'(4 * i), 32'hA0 + 32'(i));
            @(negedge clk);
            check_output("hold s_addr", 64'(s_addr), 64'h200 + 64'(4 * i));
            check_output("hold grant", 64'(grant), 64'h2);
        end
        step();
        apply_stimulus(1, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        check_output("hold release s_cyc", 64'(s_cyc), 64'h0);
        step();
        @(negedge clk);
        check_output("hold m0 grant", 64'(grant), 64'h1);
        check_output("hold m0 s_addr", 64'(s_addr), 64'h400);
        check_output("hold m0 s_we", 64'(s_we), 64'h0);
        step();
        apply_stimulus(0, 0, 0, 0, 32'h0, 32'h0);
        step();

        // Timeout on an m1 write that is never acked
        ack_en = 1'b0;
        apply_stimulus(1, 1, 1, 1, 32'h500, 32'h55);
        stb_at = -1; err_at = -1; err_cnt = 0;
        for (int i = 1; i <= 12; i++) begin
            step();
            @(negedge clk);
            if (s_stb && stb_at < 0) stb_at = i;
            if (m1_err) begin
                err_cnt++;
                if (err_at < 0) err_at = i;
            end
        end
        check_output("timeout latency", 64'(err_at - stb_at), 64'(TO));
        check_output("timeout err pulses", 64'(err_cnt), 64'h1);
        check_output("timeout locked grant", 64'(grant), 64'h0);
        step();
        apply_stimulus(1, 0, 0, 0, 32'h0, 32'h0);
        step();
        apply_stimulus(1, 1, 1, 1, 32'h504, 32'h56);
        step();
        @(negedge clk);
        check_output("timeout regrant", 64'(grant), 64'h2);
        step();
        apply_stimulus(1, 0, 0, 0, 32'h0, 32'h0);
        step();

        // Ack exactly at the limit is a normal completion
        apply_stimulus(0, 1, 1, 0, 32'h600, 32'h0);
        step();
        for (int i = 0; i < 8; i++) step();
        ack_en = 1'b1;
        @(negedge clk);
        check_output("limit m0_ack", 64'(m0_ack), 64'h1);
        check_output("limit m0_err", 64'(m0_err), 64'h0);
        step();
        ack_en = 1'b0;
        @(negedge clk);
        check_output("limit grant kept", 64'(grant), 64'h1);
        step();
        apply_stimulus(0, 0, 0, 0, 32'h0, 32'h0);
        step();

        // Reset in the middle of an m0 transfer
        apply_stimulus(0, 1, 1, 0, 32'h700, 32'h0);
        step();
        @(negedge clk);
        check_output("rst pre grant", 64'(grant), 64'h1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_output("rst async grant", 64'(grant), 64'h0);
        check_output("rst async s_cyc", 64'(s_cyc), 64'h0);
        step();
        rst = 1'b0;
        apply_stimulus(0, 0, 0, 0, 32'h0, 32'h0);
        apply_stimulus(1, 1, 1, 0, 32'h800, 32'h0);
        @(negedge clk);
        check_output("rst idle grant", 64'(grant), 64'h0);
        step();
        @(negedge clk);
        check_output("rst m1 grant", 64'(grant), 64'h2);
        step();
        apply_stimulus(1, 0, 0, 0, 32'h0, 32'h0);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master Wishbone-classic arbiter that shares one slave port, the controller's single memory/bus port, between an instruction-fetch master (m0) and a data master (m1). It sits between a core with split fetch/data buses and the processor_ci Controller bus (`core_*`). It provides:
- round-robin arbitration, with the grant held for the whole `cyc` tenure;
- routing of ack and read data to the owner only;
- a per-transfer timeout watchdog that returns an error pulse and frees the bus if the slave never acks.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width.
- `DATA_WIDTH`, 32, data width.
- `TIMEOUT_CYCLES`, 1024, wait cycles without ack before error; 0 disables the watchdog.

Ports:
- `clk`  in  1  single clock; all state is on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `m0_cyc`, `m0_stb`, `m0_we`  in  1 each  master 0 (instruction) request.
- `m0_addr`  in  ADDR_WIDTH  master 0 address.
- `m0_data_out`  in  DATA_WIDTH  master 0 write data.
- `m0_data_in`  out  DATA_WIDTH  read data to master 0.
- `m0_ack`, `m0_err`  out  1 each  master 0 completion / timeout error.
- `m1_*`  same set and directions as m0, for master 1 (data).
- `s_cyc`, `s_stb`, `s_we`  out  1 each  slave request.
- `s_addr`  out  ADDR_WIDTH  slave address.
- `s_data_out`  out  DATA_WIDTH  slave write data.
- `s_data_in`  in  DATA_WIDTH  slave read data.
- `s_ack`  in  1  slave acknowledge.
- `grant`  out  2  one-hot owner: 01 = m0, 10 = m1, 00 = idle.

## Operation
- FSM states: IDLE, GNT0, GNT1. Registered state; `grant` is decoded directly from state.
- `last` register holds the most recently granted master. Reset value is 1, so m0 wins the first tie.
- IDLE transitions:
  - only m0_cyc → GNT0;
  - only m1_cyc → GNT1;
  - both → the master ≠ `last`;
  - neither → stay IDLE.
- On entering GNTn, `last` is set to n.
- GNTn behaviour:
  - Stay in GNTn while mn_cyc = 1. Back-to-back transfers under one cyc keep the grant, with no preemption.
  - If mn_cyc = 0 and the other master's cyc = 1 → go directly to the other GNT state (handoff).
  - If mn_cyc = 0 and the other master's cyc = 0 → IDLE.
- Slave mux is combinational from state:
  - In GNTn: s_cyc = mn_cyc, s_stb = mn_stb, and s_we, s_addr and s_data_out = master n's signals.
  - In IDLE: all s_* outputs are 0.
- Return path:
  - mn_ack = s_ack & grant[n] & mn_stb.
  - m0_data_in and m1_data_in both = s_data_in, without gating.
  - The non-owner's ack and err are always 0.
- Watchdog:
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
  - The counter increments each cycle that s_stb = 1 and s_ack = 0.
  - It clears on s_ack, on any state change, and in IDLE.
  - When count == TIMEOUT_CYCLES and s_ack = 0, the owner's err = 1 for that cycle, and the next state is IDLE regardless of cyc.
- Post-error lockout: after an err, master n is not re-granted until it has deasserted cyc for at least one cycle. Track this with a per-master `err_lock` bit, cleared when mn_cyc = 0.
- An ack arriving in the same cycle the counter reaches the limit counts as an ack, not an error.

## Timing
- Reset state (asynchronous, immediate): state = IDLE, last = 1, counter = 0, err_lock = 0.
- Outputs while in reset: grant = 00; all s_* = 0; all ack and err = 0. A transfer in flight when reset asserts is dropped.
- Grant latency: cyc asserted in cycle t while IDLE → grant and s_cyc visible in cycle t+1.
- Zero-wait slave (combinational ack in t+1) → mn_ack in t+1.
- Release: mn_cyc = 0 in cycle k → s_cyc = 0 in cycle k (combinational). The other master is granted in k+1 via handoff, so there are no dead cycles between owners.
- Ack and err are combinational from s_ack and the counter, so they add no register delay.
- Error timing: stb held with no ack from cycle t gives err in cycle t+TIMEOUT_CYCLES. s_cyc = 0 from the following cycle.
- With TIMEOUT_CYCLES = 0: err is never asserted and the counter is held at 0.

## Test plan
- Single master: m0 reads address 0x100, slave acks 1 cycle after stb with 0xDEADBEEF → grant = 01 in t+1; m0_ack = 1 with m0_data_in = 0xDEADBEEF; m1_ack = 0 throughout.
- Tie from reset: m0_cyc and m1_cyc both rise in the same cycle, each makes one transfer then drops cyc → grant sequence 01 then 10 with no IDLE cycle between. Repeat the tie → 01 first again, because last = 1 after the m1 grant.
- Hold under contention: m1 keeps cyc and does 4 back-to-back writes (0x200–0x20C) while m0 requests → m0 waits. m0 is granted the cycle after m1_cyc drops, and s_we/s_addr follow m0 from that cycle.
- Timeout: TIMEOUT_CYCLES = 8, slave never acks an m1 write → m1_err = 1 exactly 8 cycles after s_stb rose, for one cycle. Then grant = 00 while m1_cyc stays high. Once m1_cyc drops and re-asserts, m1 is granted again.
- Ack at limit: slave acks exactly at count == 8 → ack = 1, err = 0, grant retained.
- Reset mid-transfer: assert rst while in GNT0 with stb = 1 → grant = 00 and s_cyc = 0 immediately (same cycle, asynchronous). After release, m1 alone requesting → GNT1 next cycle.
